// File: rtl/ascon_round_sequencer_if.sv
// Handshake and round-schedule bundle between the ASCON round sequencer and its
// controller / permutation datapath.
interface ascon_round_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             start_i;
  logic [1:0]       mode_i;
  logic [CNT_W-1:0] rounds_i;
  logic             enable_i;
  logic             abort_i;
  logic             ready_o;
  logic             busy_o;
  logic [CNT_W-1:0] round_o;
  logic [7:0]       rc_o;
  logic             last_o;
  logic             done_o;
  logic             err_o;

  modport master (
    output start_i, mode_i, rounds_i, enable_i, abort_i,
    input  ready_o, busy_o, round_o, rc_o, last_o, done_o, err_o
  );

  modport slave (
    input  start_i, mode_i, rounds_i, enable_i, abort_i,
    output ready_o, busy_o, round_o, rc_o, last_o, done_o, err_o
  );
endinterface

// File: rtl/ascon_round_sequencer.sv
// Start/busy/done round scheduler for the ASCON permutation: runs n rounds ending at
// index ROUNDS_A-1 and presents the round index and its round constant each cycle.
module ascon_round_sequencer #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6,
  parameter int CNT_W    = 4
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  ascon_round_sequencer_if.slave       bus
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_RUN   = 1'b1;
  localparam logic [CNT_W-1:0] RA_C     = CNT_W'(ROUNDS_A);
  localparam logic [CNT_W-1:0] RB_C     = CNT_W'(ROUNDS_B);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS_A - 1);

  // Round constant: upper nibble counts down from F while the lower counts up.
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    return {4'hF - idx, idx};
  endfunction

  logic [0:0]       state_r;
  logic [0:0]       state_n_s;
  logic [CNT_W-1:0] round_r;
  logic [CNT_W-1:0] round_n_s;
  logic             done_r;
  logic             done_n_s;
  logic             err_r;
  logic             err_n_s;

  logic             busy_s;
  logic             last_s;
  logic             ready_s;
  logic             legal_s;
  logic [CNT_W-1:0] n_s;
  logic [CNT_W-1:0] start_idx_s;
  logic             start_req_s;

  assign busy_s      = (state_r == ST_RUN);
  assign last_s      = busy_s & (round_r == LAST_IDX);
  assign ready_s     = ~busy_s | (last_s & bus.enable_i);
  assign start_req_s = bus.start_i & ready_s;
  assign start_idx_s = RA_C - n_s;

  // Decode the requested round count and whether the request is legal.
  always_comb begin
    n_s     = RA_C;
    legal_s = 1'b0;
    case (bus.mode_i)
      2'd0: begin
        n_s     = RA_C;
        legal_s = 1'b1;
      end
      2'd1: begin
        n_s     = RB_C;
        legal_s = 1'b1;
      end
      2'd2: begin
        n_s     = bus.rounds_i;
        legal_s = (bus.rounds_i >= {{(CNT_W-1){1'b0}}, 1'b1}) && (bus.rounds_i <= RA_C);
      end
      default: begin
        n_s     = RA_C;
        legal_s = 1'b0;
      end
    endcase
  end

  // Next-state logic: abort, then completion/advance, then start acceptance.
  always_comb begin
    state_n_s = state_r;
    round_n_s = round_r;
    done_n_s  = 1'b0;
    err_n_s   = 1'b0;
    if (busy_s && bus.abort_i) begin
      state_n_s = ST_IDLE;
    end else if (busy_s) begin
      if (bus.enable_i) begin
        if (last_s) begin
          done_n_s = 1'b1;
          if (start_req_s && legal_s) begin
            round_n_s = start_idx_s;
          end else begin
            // Run ends; a rejected start on the final cycle still flags an error.
            state_n_s = ST_IDLE;
            err_n_s   = start_req_s;
          end
        end else begin
          round_n_s = round_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        state_n_s = state_r;
      end
    end else begin
      if (start_req_s) begin
        if (legal_s) begin
          state_n_s = ST_RUN;
          round_n_s = start_idx_s;
        end else begin
          err_n_s = 1'b1;
        end
      end else begin
        state_n_s = state_r;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r <= ST_IDLE;
      round_r <= {CNT_W{1'b0}};
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n_s;
      round_r <= round_n_s;
      done_r  <= done_n_s;
      err_r   <= err_n_s;
    end
  end

  assign bus.busy_o  = busy_s;
  assign bus.round_o = round_r;
  assign bus.rc_o    = round_const(round_r[3:0]);
  assign bus.last_o  = last_s;
  assign bus.ready_o = ready_s;
  assign bus.done_o  = done_r;
  assign bus.err_o   = err_r;

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Directed plus randomized bench for ascon_round_sequencer against a cycle-level
// behavioural model of the round schedule.
module tb_ascon_round_sequencer;

  localparam int RA = 12;
  localparam int RB = 6;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  // model state
  int m_busy, m_round, m_done, m_err;

  ascon_round_sequencer_if #(.CNT_W(4)) bus ();

  ascon_round_sequencer #(.ROUNDS_A(RA), .ROUNDS_B(RB), .CNT_W(4)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int req_n(input int mode, input int rounds);
    if (mode == 0) return RA;
    if (mode == 1) return RB;
    if (mode == 2 && rounds >= 1 && rounds <= RA) return rounds;
    return 0;
  endfunction

  // One clock: advance the model from the current inputs, then compare every output.
  task automatic tick();
    int n, last, ready, start_ok;
    int nb, nr, nd, ne;
    n        = req_n(int'(bus.mode_i), int'(bus.rounds_i));
    last     = (m_busy != 0 && m_round == RA - 1) ? 1 : 0;
    ready    = (m_busy == 0 || (last != 0 && bus.enable_i)) ? 1 : 0;
    start_ok = (bus.start_i && ready != 0) ? 1 : 0;
    nb = m_busy; nr = m_round; nd = 0; ne = 0;
    if (rst) begin
      nb = 0; nr = 0;
    end else if (m_busy != 0 && bus.abort_i) begin
      nb = 0;
    end else if (m_busy != 0) begin
      if (bus.enable_i && last != 0) begin
        nd = 1;
        if (start_ok != 0 && n != 0) nr = RA - n;
        else begin nb = 0; ne = start_ok; end
      end else if (bus.enable_i) begin
        nr = m_round + 1;
      end
    end else if (start_ok != 0) begin
      if (n != 0) begin nb = 1; nr = RA - n; end
      else ne = 1;
    end
    @(posedge clk);
    #1;
    m_busy = nb; m_round = nr; m_done = nd; m_err = ne;
    last  = (m_busy != 0 && m_round == RA - 1) ? 1 : 0;
    ready = (m_busy == 0 || (last != 0 && bus.enable_i)) ? 1 : 0;
    chk("busy",  int'(bus.busy_o),  m_busy);
    chk("round", int'(bus.round_o), m_round);
    chk("rc",    int'(bus.rc_o),    (15 - m_round) * 16 + m_round);
    chk("last",  int'(bus.last_o),  last);
    chk("ready", int'(bus.ready_o), ready);
    chk("done",  int'(bus.done_o),  m_done);
    chk("err",   int'(bus.err_o),   m_err);
  endtask

  task automatic set_in(input logic s, input logic [1:0] m, input logic [3:0] r,
                        input logic e, input logic a);
    bus.start_i = s; bus.mode_i = m; bus.rounds_i = r; bus.enable_i = e; bus.abort_i = a;
  endtask

  initial begin
    int rc_tab [12];
    int cnt;
    rc_tab = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
    vectors = 0; miscompares = 0;
    m_busy = 0; m_round = 0; m_done = 0; m_err = 0;
    rst = 1'b1;
    set_in(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_rc", int'(bus.rc_o), 8'hF0);
    chk("rst_ready", int'(bus.ready_o), 1);

    // 1: full p^a run with its constant sequence
    set_in(1'b1, 2'd0, 4'd0, 1'b1, 1'b0);
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("t1_rc", int'(bus.rc_o), rc_tab[k]);
      chk("t1_last", int'(bus.last_o), (k == 11) ? 1 : 0);
      tick();
    end
    chk("t1_done", int'(bus.done_o), 1);
    chk("t1_busy", int'(bus.busy_o), 0);
    tick();
    chk("t1_done_clr", int'(bus.done_o), 0);

    // 2: p^b run starts at index 6
    set_in(1'b1, 2'd1, 4'd0, 1'b1, 1'b0);
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("t2_round", int'(bus.round_o), 6 + k);
      chk("t2_rc", int'(bus.rc_o), rc_tab[6 + k]);
      tick();
    end
    chk("t2_done", int'(bus.done_o), 1);

    // 3: stall at round 5 for three cycles
    set_in(1'b1, 2'd0, 4'd0, 1'b1, 1'b0);
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    bus.enable_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_hold_round", int'(bus.round_o), 5);
      chk("t3_hold_rc", int'(bus.rc_o), 8'hA5);
    end
    bus.enable_i = 1'b1;
    cnt = 8;
    while (!bus.done_o && cnt < 40) begin tick(); cnt++; end
    chk("t3_done_cycle", cnt, 15);

    // 4: back-to-back p^b then custom 3-round run
    set_in(1'b1, 2'd1, 4'd0, 1'b1, 1'b0);
    tick();
    bus.start_i = 1'b0;
    cnt = 0;
    while (!bus.last_o && cnt < 20) begin tick(); cnt++; end
    chk("t4_reach_last", int'(bus.round_o), 11);
    set_in(1'b1, 2'd2, 4'd3, 1'b1, 1'b0);
    chk("t4_ready", int'(bus.ready_o), 1);
    tick();
    bus.start_i = 1'b0;
    chk("t4_done1", int'(bus.done_o), 1);
    chk("t4_busy", int'(bus.busy_o), 1);
    chk("t4_round9", int'(bus.round_o), 9);
    tick(); chk("t4_round10", int'(bus.round_o), 10);
    tick(); chk("t4_round11", int'(bus.round_o), 11);
    tick(); chk("t4_done2", int'(bus.done_o), 1);
    chk("t4_idle", int'(bus.busy_o), 0);

    // 5: illegal requests
    set_in(1'b1, 2'd2, 4'd0, 1'b1, 1'b0);
    tick(); chk("t5_err0", int'(bus.err_o), 1); chk("t5_busy0", int'(bus.busy_o), 0);
    bus.start_i = 1'b0; tick(); chk("t5_err_clr", int'(bus.err_o), 0);
    set_in(1'b1, 2'd2, 4'd13, 1'b1, 1'b0);
    tick(); chk("t5_err13", int'(bus.err_o), 1);
    bus.start_i = 1'b0; tick();
    set_in(1'b1, 2'd3, 4'd4, 1'b1, 1'b0);
    tick(); chk("t5_err_m3", int'(bus.err_o), 1); chk("t5_busy_m3", int'(bus.busy_o), 0);
    bus.start_i = 1'b0; tick();

    // 6: abort at round 8, then reset at round 3
    set_in(1'b1, 2'd0, 4'd0, 1'b1, 1'b0);
    tick();
    bus.start_i = 1'b0;
    cnt = 0;
    while (bus.round_o != 4'd8 && cnt < 20) begin tick(); cnt++; end
    chk("t6_reach8", int'(bus.round_o), 8);
    bus.abort_i = 1'b1; bus.start_i = 1'b1;
    tick();
    bus.abort_i = 1'b0; bus.start_i = 1'b0;
    chk("t6_abort_busy", int'(bus.busy_o), 0);
    chk("t6_abort_err", int'(bus.err_o), 0);
    tick(); chk("t6_no_done", int'(bus.done_o), 0);
    set_in(1'b1, 2'd0, 4'd0, 1'b1, 1'b0);
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("t6_round3", int'(bus.round_o), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_busy", int'(bus.busy_o), 0);
    chk("t6_rst_round", int'(bus.round_o), 0);
    chk("t6_rst_done", int'(bus.done_o), 0);

    // randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      set_in(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
             2'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)),
             ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
      rst = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ascon_round_sequencer.md
Name: ascon_round_sequencer

Overview:
Parametrised round scheduler for the ASCON permutation core. It replaces the fixed 4-bit round counter with a start/busy/done sequencer. Each run executes a programmable number of rounds (p^a, p^b or a custom count) and drives the absolute round index and its 8-bit round constant to the permutation datapath each cycle. It supports stall, abort, back-to-back runs and illegal-request detection.

Parameters:
ROUNDS_A, 12, rounds for p^a (initialisation/finalisation); legal range 1..16
ROUNDS_B, 6, rounds for p^b (data processing); legal range 1..ROUNDS_A
CNT_W, 4, width of round index and round-count fields; must hold ROUNDS_A

Ports:
clock_i  in  1  system clock, all logic on rising edge
reset_i  in  1  synchronous, active-high reset
start_i  in  1  request a new run; accepted only when ready_o=1
mode_i  in  2  0: ROUNDS_A, 1: ROUNDS_B, 2: rounds_i, 3: reserved (illegal)
rounds_i  in  CNT_W  custom round count for mode 2
enable_i  in  1  advance one round when high; stall when low
abort_i  in  1  cancel the current run
ready_o  out  1  sequencer can accept start_i this cycle
busy_o  out  1  a run is in progress
round_o  out  CNT_W  absolute round index i for the current round
rc_o  out  8  ASCON round constant for round_o
last_o  out  1  current round is the final round of the run
done_o  out  1  one-cycle pulse after the final round completes
err_o  out  1  one-cycle pulse when a start is rejected as illegal

Behaviour:
- Clock and reset: one clock (clock_i). Reset is synchronous, active-high (reset_i).
- Reset values: busy_o=0, round_o=0, done_o=0, err_o=0. ready_o=1, last_o=0 and rc_o=8'hF0 follow combinationally.
- States:
  - IDLE: busy_o=0.
  - RUN: busy_o=1.
- Round count n: selected by mode_i.
  - Mode 2 is legal only if 1 <= rounds_i <= ROUNDS_A.
  - Mode 3 is always illegal.
- Start acceptance: a start is accepted at a rising edge when start_i & ready_o, and is legal.
  - Registered start index = ROUNDS_A - n, so every run ends at index ROUNDS_A-1 (ASCON tail alignment).
  - Next state is RUN.
- Illegal start (start_i & ready_o, illegal request): err_o=1 for the next cycle; state is unchanged.
- Definitions:
  - last_o = busy_o & (round_o == ROUNDS_A-1).
  - ready_o = ~busy_o | (last_o & enable_i).
  - rc_o = {4'hF - round_o[3:0], round_o[3:0]} (combinational, 0 latency).
- In RUN:
  - enable_i=1 and ~last_o: round_o increments.
  - enable_i=1 and last_o: run completes and done_o=1 for the next cycle.
    - With an accepted start in the same cycle, round_o loads the new start index and busy_o stays 1 (zero-bubble back-to-back run).
    - Otherwise busy_o clears and round_o holds.
  - enable_i=0: all state is frozen; last_o/rc_o hold; no done_o.
- Latency: with enable_i held high, a start accepted at edge T yields round_o = start index at T+1, last_o at cycle T+n, and done_o at cycle T+n+1. Total run is n cycles plus 1 cycle for the done pulse.
- Abort:
  - abort_i=1 forces IDLE next cycle and suppresses done_o.
  - abort_i has priority over enable_i and over a simultaneous start (that start is ignored; no err_o).
  - abort_i in IDLE has no effect.
- start_i while busy and ~ready_o: ignored silently; no err_o.
- Priority: reset_i > abort_i > completion/advance > start.
- Reset asserted mid-run: next cycle matches reset values; no done_o.
- Arithmetic: unsigned. round_o never exceeds ROUNDS_A-1 and never wraps.

Test Plan:
1. Reset, then start_i with mode 0 and enable_i held high -> rc_o = F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B over 12 cycles; last_o with 4B; done_o at T+13; busy_o=0 afterwards.
2. Mode 1 start -> round_o = 6..11, rc_o = 96,87,78,69,5A,4B; done_o at T+7.
3. Mode 0 run; drop enable_i for 3 cycles at round 5 -> round_o/rc_o hold at 5/A5; done_o delayed 3 cycles, at T+16.
4. Mode 1 run with a mode 2, rounds_i=3 start on the last_o cycle -> no idle gap; round_o = 11 then 9,10,11; done_o pulses twice, with busy_o continuously high between them.
5. Mode 2 with rounds_i=0, then rounds_i=13, then mode 3 -> err_o pulses once per request; busy_o stays 0.
6. abort_i at round 8 of a mode 0 run -> busy_o=0 next cycle, no done_o. Separately, reset_i at round 3 -> reset values next cycle.
